// File: rtl/phase_slot_arbiter.sv
// phase_slot_arbiter
//
// Shares one memory/bus port between NUM_REQ requesters. The 3-bit clock phase
// counter defines an 8-phase frame of four 2-cycle slots (slot = clockPhase[2:1]).
// Slots flagged in RESERVED_MASK belong to requester 0 whenever it requests.
// All other slots are arbitrated round-robin. A locked owner may hold up to
// MAX_BURST consecutive slots.
//
// Ports:
//   clock         in   system clock
//   reset         in   asynchronous, active-high reset
//   clockPhase_i  in   [2:0] phase from the clock phase generator (+1 per clock)
//   req_i         in   [NUM_REQ-1:0] bus request, held until ack
//   lock_i        in   [NUM_REQ-1:0] burst request, qualified by req_i
//   grant_o       out  [NUM_REQ-1:0] one-hot registered grant, constant per slot
//   owner_o       out  index of granted requester, 0 when no grant
//   busValid_o    out  OR of grant_o
//   ack_o         out  [NUM_REQ-1:0] completion pulse in the slot's odd phase
module phase_slot_arbiter #(
    parameter int         NUM_REQ       = 4,
    parameter logic [3:0] RESERVED_MASK = 4'b0001,
    parameter int         MAX_BURST     = 4
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic [2:0]                 clockPhase_i,
    input  logic [NUM_REQ-1:0]         req_i,
    input  logic [NUM_REQ-1:0]         lock_i,
    output logic [NUM_REQ-1:0]         grant_o,
    output logic [$clog2(NUM_REQ)-1:0] owner_o,
    output logic                       busValid_o,
    output logic [NUM_REQ-1:0]         ack_o
);

    localparam int         OW        = $clog2(NUM_REQ);
    localparam logic [3:0] BURST_LIM = 4'(MAX_BURST - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        OWNED = 2'd1,
        BURST = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [NUM_REQ-1:0] grant_q, grant_d;
    logic [OW-1:0]      owner_q, owner_d;
    logic [OW-1:0]      rrPtr_q, rrPtr_d;
    logic [3:0]         burstCount_q, burstCount_d;

    logic               decide;
    logic [1:0]         nextSlot;
    logic               rrFound;
    logic [OW-1:0]      rrWin;
    logic [OW-1:0]      rrNext;

    // The last cycle of each slot (odd phase) decides the owner of the next slot.
    assign decide   = clockPhase_i[0];
    assign nextSlot = clockPhase_i[2:1] + 2'd1;

    // Round-robin search starting at rrPtr, wrapping modulo NUM_REQ.
    always_comb begin
        int idx;
        rrFound = 1'b0;
        rrWin   = '0;
        rrNext  = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = (int'(rrPtr_q) + k) % NUM_REQ;
            if (!rrFound && req_i[idx]) begin
                rrFound = 1'b1;
                rrWin   = OW'(idx);
                rrNext  = OW'((idx + 1) % NUM_REQ);
            end
        end
    end

    // Next-state logic: outcome only changes at decision points.
    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        owner_d      = owner_q;
        rrPtr_d      = rrPtr_q;
        burstCount_d = burstCount_q;

        if (decide) begin
            if (RESERVED_MASK[nextSlot] && req_i[0]) begin
                // Reserved slot: requester 0 preempts, any running burst ends.
                grant_d      = '0;
                grant_d[0]   = 1'b1;
                owner_d      = '0;
                burstCount_d = '0;
                state_d      = OWNED;
            end else if ((state_q == OWNED || state_q == BURST) &&
                         req_i[owner_q] && lock_i[owner_q] &&
                         (burstCount_q < BURST_LIM)) begin
                // Locked owner keeps the bus for one more slot.
                burstCount_d = burstCount_q + 4'd1;
                state_d      = BURST;
            end else if (rrFound) begin
                grant_d        = '0;
                grant_d[rrWin] = 1'b1;
                owner_d        = rrWin;
                rrPtr_d        = rrNext;
                burstCount_d   = '0;
                state_d        = OWNED;
            end else begin
                grant_d      = '0;
                owner_d      = '0;
                burstCount_d = '0;
                state_d      = IDLE;
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            grant_q      <= '0;
            owner_q      <= '0;
            rrPtr_q      <= '0;
            burstCount_q <= '0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            owner_q      <= owner_d;
            rrPtr_q      <= rrPtr_d;
            burstCount_q <= burstCount_d;
        end
    end

    assign grant_o    = grant_q;
    assign owner_o    = owner_q;
    assign busValid_o = |grant_q;
    // Ack only if the owner still requests in the slot's final cycle; a grant
    // cleared by reset yields no ack for the aborted slot.
    assign ack_o      = decide ? (grant_q & req_i) : '0;

endmodule

// File: tb/tb_phase_slot_arbiter.sv
module tb_phase_slot_arbiter;

    logic       clock;
    logic       reset;
    logic [2:0] ph;
    logic [3:0] req;
    logic [3:0] lock;
    logic [3:0] grant;
    logic [1:0] owner;
    logic       busValid;
    logic [3:0] ack;

    int total = 0;
    int bad   = 0;

    typedef struct {
        int own;
        bit ak;
    } exp_t;

    exp_t sbq[$];

    phase_slot_arbiter #(
        .NUM_REQ      (4),
        .RESERVED_MASK(4'b0001),
        .MAX_BURST    (4)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .clockPhase_i(ph),
        .req_i       (req),
        .lock_i      (lock),
        .grant_o     (grant),
        .owner_o     (owner),
        .busValid_o  (busValid),
        .ack_o       (ack)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Phase generator, cleared together with the arbiter.
    always @(posedge clock or posedge reset) begin
        if (reset) ph <= 3'd0;
        else       ph <= ph + 3'd1;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        total++;
        if (act !== expv) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, expv, $time);
        end
    endtask

    task automatic push(input int o, input bit a);
        exp_t e;
        e.own = o;
        e.ak  = a;
        sbq.push_back(e);
    endtask

    task automatic push_seq(input int s[$]);
        foreach (s[i]) push(s[i], s[i] >= 0);
    endtask

    // Monitor: each slot is checked in its odd-phase cycle, away from the edge.
    always @(negedge clock) begin
        if (!reset && ph[0]) begin
            if (sbq.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_slot: got grant=%0h expected no pending slot", grant);
            end else begin
                exp_t e;
                logic [3:0] eg;
                e  = sbq.pop_front();
                eg = (e.own < 0) ? 4'd0 : (4'd1 << e.own);
                chk("grant", 32'(grant), 32'(eg));
                chk("owner", 32'(owner), (e.own < 0) ? 32'd0 : 32'(e.own));
                chk("busValid", 32'(busValid), 32'(e.own >= 0));
                chk("ack", 32'(ack), e.ak ? 32'(eg) : 32'd0);
            end
        end
    end

    task automatic begin_scn(input logic [3:0] r, input logic [3:0] l);
        @(posedge clock);
        #1 reset = 1'b1;
        req  = r;
        lock = l;
        @(posedge clock);
        #1 reset = 1'b0;
    endtask

    task automatic wait_drain(input string name);
        int n = 0;
        while (sbq.size() != 0 && n < 200) begin
            @(posedge clock);
            n++;
        end
        if (sbq.size() != 0) begin
            total++;
            bad++;
            $display("FAIL %s_timeout: got %0d pending slots expected 0", name, sbq.size());
            sbq.delete();
        end
    endtask

    task automatic wait_phase(input logic [2:0] p);
        int n = 0;
        do begin
            @(posedge clock);
            #1;
            n++;
        end while (ph != p && n < 50);
        if (ph != p) begin
            total++;
            bad++;
            $display("FAIL phase_timeout: got phase %0d expected %0d", ph, p);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int s_idle[$];
        int s_r0[$];
        int s_rr[$];
        int s_bl[$];
        int s_pre[$];
        int s_rst[$];

        s_idle = '{-1, -1, -1, -1, -1, -1, -1, -1};
        s_r0   = '{-1, 0, 0, 0, 0, 0, 0, 0, 0};
        s_rr   = '{-1, 1, 2, 3, 1, 2, 3, 1};
        s_bl   = '{-1, 1, 1, 1, 1, 2, 1, 1, 1, 1, 2};
        s_pre  = '{-1, 0, 1, 1, 0, 0, 1, 1, 0};
        s_rst  = '{-1, 1, 2, 3};

        reset = 1'b0;
        req   = '0;
        lock  = '0;
        #2 reset = 1'b1;
        repeat (2) @(posedge clock);
        #1;
        chk("reset_grant", 32'(grant), 32'd0);
        chk("reset_owner", 32'(owner), 32'd0);
        chk("reset_busValid", 32'(busValid), 32'd0);
        chk("reset_ack", 32'(ack), 32'd0);

        // No requests: 16 cycles of idle slots.
        push_seq(s_idle);
        begin_scn(4'b0000, 4'b0000);
        wait_drain("idle");

        // Requester 0 alone: owns every slot after the idle first slot.
        push_seq(s_r0);
        begin_scn(4'b0001, 4'b0000);
        wait_drain("req0_only");

        // Round robin among 1..3; reserved slot reclaimed while req[0] low.
        push_seq(s_rr);
        begin_scn(4'b1110, 4'b0000);
        wait_drain("round_robin");

        // Locked burst by 1 capped at four slots, requester 2 then wins.
        push_seq(s_bl);
        begin_scn(4'b0110, 4'b0010);
        wait_drain("burst_limit");

        // Reserved-slot preemption breaks requester 1's burst.
        push_seq(s_pre);
        begin_scn(4'b0011, 4'b0010);
        wait_drain("preempt");

        // Owner drops req at the even phase: slot runs out with no ack.
        push(-1, 1'b0);
        push(1, 1'b1);
        push(1, 1'b0);
        push(2, 1'b1);
        push(2, 1'b1);
        begin_scn(4'b0010, 4'b0000);
        wait_phase(3'd4);
        req = 4'b0100;
        wait_drain("drop_req");

        // Reset mid-slot while requester 2 owns slot 2.
        push(-1, 1'b0);
        push(1, 1'b1);
        begin_scn(4'b1110, 4'b0000);
        wait_phase(3'd4);
        chk("pre_reset_grant", 32'(grant), 32'h4);
        reset = 1'b1;
        #1;
        chk("midreset_grant", 32'(grant), 32'd0);
        chk("midreset_owner", 32'(owner), 32'd0);
        chk("midreset_busValid", 32'(busValid), 32'd0);
        chk("midreset_ack", 32'(ack), 32'd0);
        sbq.delete();
        push_seq(s_rst);
        @(posedge clock);
        #1 reset = 1'b0;
        wait_drain("after_reset");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
